// File: rtl/picorv32_bus_bridge.sv
// picorv32_bus_bridge: registered bridge from the PicoRV32 native memory
// interface to the system bus. One access in flight; IDLE -> BUS -> DONE.
// Optional access timeout is compiled in with `define PICORV32_BRIDGE_TIMEOUT_EN.
module picorv32_bus_bridge #(
    parameter int unsigned BUS_DW         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst_n,
    // CPU side
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    // System bus side
    output logic [31:0]         bus_addr,
    output logic                bus_instr,
    output logic                bus_read,
    output logic                bus_write,
    output logic [BUS_DW-1:0]   bus_writedata,
    output logic [BUS_DW/8-1:0] bus_byteenable,
    input  logic [BUS_DW-1:0]   bus_readdata,
    input  logic [1:0]          bus_response,
    input  logic                bus_waitrequest,
    // Error reporting
    output logic                err_irq,
    output logic [31:0]         err_addr
);

    // Elaboration-time parameter sanity checks
    if (BUS_DW != 32 && BUS_DW != 64) begin : g_bad_bus_dw
        $error("picorv32_bus_bridge: BUS_DW must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("picorv32_bus_bridge: TIMEOUT_CYCLES must be >= 2");
    end

    localparam int unsigned NumLanes = BUS_DW / 32;
    // Clears log2(BUS_DW/8) low address bits
    localparam logic [31:0] AddrMask = ~(32'(BUS_DW / 8) - 32'd1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] err_addr_q;

    logic        latch;      // accept a new CPU request this cycle
    logic        finish;     // leave BUS this cycle (completion or timeout)
    logic        fail;       // the access that is finishing is an error
    logic        timeout_hit;
    logic        lane;
    logic [31:0] rd_lane;
    logic        is_read;

    assign is_read = (wstrb_q == 4'b0000);

    // Lane selection: only a 64-bit bus has a second 32-bit lane
    if (BUS_DW == 64) begin : g_lane64
        assign lane    = addr_q[2];
        assign rd_lane = addr_q[2] ? bus_readdata[63:32] : bus_readdata[31:0];
    end else begin : g_lane32
        assign lane    = 1'b0;
        assign rd_lane = bus_readdata[31:0];
    end

`ifdef PICORV32_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // Counts BUS cycles; holds CntLast during the TIMEOUT_CYCLES-th one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (latch) begin
            cnt_q <= '0;
        end else if (state_q == StBus) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign timeout_hit = bus_waitrequest && (cnt_q == CntLast);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic; completion takes priority over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        finish  = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    latch   = 1'b1;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (!bus_waitrequest) begin
                    finish  = 1'b1;
                    fail    = (bus_response != 2'b00);
                    state_d = StDone;
                end else if (timeout_hit) begin
                    finish  = 1'b1;
                    fail    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
        end else if (latch) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
        end
    end

    // Response capture: read data and error status are sampled only when leaving BUS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (finish) begin
            err_q <= fail;
            if (!is_read) begin
                rdata_q <= '0;
            end else if (fail) begin
                rdata_q <= ERR_RDATA;
            end else begin
                rdata_q <= rd_lane;
            end
            if (fail) begin
                err_addr_q <= addr_q;
            end
        end
    end

    // Byte enables: read enables a whole word, then steered into the addressed lane
    always_comb begin
        bus_byteenable = '0;
        if (state_q == StBus) begin
            bus_byteenable[3:0] = is_read ? 4'hF : wstrb_q;
            if (lane) begin
                bus_byteenable = bus_byteenable << 4;
            end
        end
    end

    // Bus and CPU outputs, all derived from registers
    assign bus_addr      = addr_q & AddrMask;
    assign bus_instr     = instr_q;
    assign bus_writedata = {NumLanes{wdata_q}};
    assign bus_read      = (state_q == StBus) && is_read;
    assign bus_write     = (state_q == StBus) && !is_read;
    assign mem_ready     = (state_q == StDone);
    assign mem_rdata     = rdata_q;
    assign err_irq       = (state_q == StDone) && err_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_picorv32_bus_bridge.sv
// Bench for picorv32_bus_bridge: a 64-bit and a 32-bit instance share the CPU
// side and bus timing. The access task sets per-cycle expectations from the
// access timeline; one compare process checks both DUTs every cycle.
module tb_picorv32_bus_bridge;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [63:0] bus_readdata;
    logic [1:0]  bus_response;
    logic        bus_waitrequest;

    logic        mem_ready_a, bus_instr_a, bus_read_a, bus_write_a, err_irq_a;
    logic [31:0] mem_rdata_a, bus_addr_a, err_addr_a;
    logic [63:0] bus_writedata_a;
    logic [7:0]  bus_byteenable_a;

    logic        mem_ready_b, bus_instr_b, bus_read_b, bus_write_b, err_irq_b;
    logic [31:0] mem_rdata_b, bus_addr_b, err_addr_b;
    logic [31:0] bus_writedata_b;
    logic [3:0]  bus_byteenable_b;

    picorv32_bus_bridge #(.BUS_DW(64), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready_a), .mem_rdata(mem_rdata_a),
        .bus_addr(bus_addr_a), .bus_instr(bus_instr_a), .bus_read(bus_read_a),
        .bus_write(bus_write_a), .bus_writedata(bus_writedata_a),
        .bus_byteenable(bus_byteenable_a), .bus_readdata(bus_readdata),
        .bus_response(bus_response), .bus_waitrequest(bus_waitrequest),
        .err_irq(err_irq_a), .err_addr(err_addr_a)
    );

    picorv32_bus_bridge #(.BUS_DW(32), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready_b), .mem_rdata(mem_rdata_b),
        .bus_addr(bus_addr_b), .bus_instr(bus_instr_b), .bus_read(bus_read_b),
        .bus_write(bus_write_b), .bus_writedata(bus_writedata_b),
        .bus_byteenable(bus_byteenable_b), .bus_readdata(bus_readdata[31:0]),
        .bus_response(bus_response), .bus_waitrequest(bus_waitrequest),
        .err_irq(err_irq_b), .err_addr(err_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected state of the current cycle
    bit          chk_en = 1'b0;
    bit          e_strobe, e_ready, e_irq, e_rdchk, e_instr;
    logic [31:0] e_addr, e_wdata, e_err_addr, e_rdata64, e_rdata32;
    logic [3:0]  e_wstrb;

    // Snapshots for literal checks after each access
    int          snap_strobes, snap_irq;
    logic [31:0] snap_rdata_a, snap_rdata_b, snap_addr_a, snap_addr_b, snap_err_addr;
    logic [63:0] snap_wd_a;
    logic [7:0]  snap_be_a;
    logic [3:0]  snap_be_b;
    logic        snap_instr;

    task automatic clear_snap();
        snap_strobes = 0;
        snap_irq     = 0;
    endtask

    function automatic logic [7:0] exp_be64(input logic [31:0] a, input logic [3:0] ws);
        logic [7:0] be;
        be = {4'h0, (ws == 4'h0) ? 4'hF : ws};
        return a[2] ? (be << 4) : be;
    endfunction

    // Per-cycle comparison against the expectation for both instances
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready64", {63'd0, mem_ready_a}, {63'd0, e_ready});
            chk("ready32", {63'd0, mem_ready_b}, {63'd0, e_ready});
            chk("read64", {63'd0, bus_read_a}, {63'd0, e_strobe && e_wstrb == 4'h0});
            chk("read32", {63'd0, bus_read_b}, {63'd0, e_strobe && e_wstrb == 4'h0});
            chk("write64", {63'd0, bus_write_a}, {63'd0, e_strobe && e_wstrb != 4'h0});
            chk("write32", {63'd0, bus_write_b}, {63'd0, e_strobe && e_wstrb != 4'h0});
            chk("irq64", {63'd0, err_irq_a}, {63'd0, e_irq});
            chk("irq32", {63'd0, err_irq_b}, {63'd0, e_irq});
            chk("err_addr64", {32'd0, err_addr_a}, {32'd0, e_err_addr});
            chk("err_addr32", {32'd0, err_addr_b}, {32'd0, e_err_addr});
            if (e_strobe) begin
                chk("addr64", {32'd0, bus_addr_a}, {32'd0, e_addr & 32'hFFFF_FFF8});
                chk("addr32", {32'd0, bus_addr_b}, {32'd0, e_addr & 32'hFFFF_FFFC});
                chk("be64", {56'd0, bus_byteenable_a}, {56'd0, exp_be64(e_addr, e_wstrb)});
                chk("be32", {60'd0, bus_byteenable_b},
                    {60'd0, (e_wstrb == 4'h0) ? 4'hF : e_wstrb});
                chk("wdata64", bus_writedata_a, {e_wdata, e_wdata});
                chk("wdata32", {32'd0, bus_writedata_b}, {32'd0, e_wdata});
                chk("instr64", {63'd0, bus_instr_a}, {63'd0, e_instr});
                chk("instr32", {63'd0, bus_instr_b}, {63'd0, e_instr});
            end
            if (e_ready && e_rdchk) begin
                chk("rdata64", {32'd0, mem_rdata_a}, {32'd0, e_rdata64});
                chk("rdata32", {32'd0, mem_rdata_b}, {32'd0, e_rdata32});
            end
        end
        if (bus_read_a || bus_write_a) begin
            snap_strobes++;
            snap_be_a   = bus_byteenable_a;
            snap_be_b   = bus_byteenable_b;
            snap_wd_a   = bus_writedata_a;
            snap_addr_a = bus_addr_a;
            snap_addr_b = bus_addr_b;
            snap_instr  = bus_instr_a;
        end
        if (err_irq_a) snap_irq++;
        if (mem_ready_a) begin
            snap_rdata_a  = mem_rdata_a;
            snap_rdata_b  = mem_rdata_b;
            snap_err_addr = err_addr_a;
        end
    end

    // One CPU access; called one time unit after a rising edge with the bridge idle
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic ins, input int nw, input logic [1:0] resp,
                          input logic [63:0] rd);
        int comp;
        bit to;
        bit err;
        clear_snap();
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_instr = ins;
        e_addr    = a;
        e_wdata   = wd;
        e_wstrb   = ws;
        e_instr   = ins;
        comp      = nw + 1;
        to        = 1'b0;
`ifdef PICORV32_BRIDGE_TIMEOUT_EN
        if (nw >= TO) begin
            comp = TO;
            to   = 1'b1;
        end
`endif
        @(posedge clk); #1;
        for (int p = 1; p <= comp; p++) begin
            bus_waitrequest = (p <= nw);
            bus_response    = (p == comp) ? resp : 2'b01;
            bus_readdata    = (p == comp) ? rd : ~rd;
            e_strobe        = 1'b1;
            @(posedge clk); #1;
        end
        err       = to || (resp != 2'b00);
        e_strobe  = 1'b0;
        e_ready   = 1'b1;
        e_irq     = err;
        if (err) e_err_addr = a;
        e_rdchk   = (ws == 4'h0);
        e_rdata64 = err ? 32'hDEAD_BEEF : (a[2] ? rd[63:32] : rd[31:0]);
        e_rdata32 = err ? 32'hDEAD_BEEF : rd[31:0];
        bus_response = 2'b11;
        bus_readdata = ~rd;
        @(posedge clk); #1;
        e_ready      = 1'b0;
        e_irq        = 1'b0;
        e_rdchk      = 1'b0;
        mem_valid    = 1'b0;
        bus_response = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        bus_readdata = '0; bus_response = '0; bus_waitrequest = 1'b0;
        e_strobe = 0; e_ready = 0; e_irq = 0; e_rdchk = 0; e_instr = 0;
        e_addr = '0; e_wdata = '0; e_err_addr = '0; e_rdata64 = '0; e_rdata32 = '0; e_wstrb = '0;
        clear_snap();
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        // Reset state
        chk("rst_ready", {63'd0, mem_ready_a | mem_ready_b}, 64'd0);
        chk("rst_strobes", {60'd0, bus_read_a, bus_write_a, bus_read_b, bus_write_b}, 64'd0);
        chk("rst_irq", {62'd0, err_irq_a, err_irq_b}, 64'd0);
        chk("rst_addr", {bus_addr_a, bus_addr_b}, 64'd0);
        chk("rst_err_addr", {err_addr_a, err_addr_b}, 64'd0);
        chk("rst_rdata", {mem_rdata_a, mem_rdata_b}, 64'd0);
        chk("rst_wdata", bus_writedata_a, 64'd0);
        chk("rst_be", {52'd0, bus_byteenable_a, bus_byteenable_b}, 64'd0);
        chk("rst_instr", {62'd0, bus_instr_a, bus_instr_b}, 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Read, no stall
        access(32'h104, 32'h0, 4'h0, 1'b0, 0, 2'b00, 64'hCAFE_F00D_1234_5678);
        chk("t1_rdata32", {32'd0, snap_rdata_b}, 64'h1234_5678);
        chk("t1_rdata64", {32'd0, snap_rdata_a}, 64'hCAFE_F00D);
        chk("t1_addr", {snap_addr_a, snap_addr_b}, 64'h0000_0100_0000_0104);
        chk("t1_strobes", 64'(snap_strobes), 64'd1);
        chk("t1_irq", 64'(snap_irq), 64'd0);

        // Write, stalled 3 cycles
        access(32'h10C, 32'hAABB_CCDD, 4'b0011, 1'b0, 3, 2'b00, 64'h0);
        chk("t2_be64", {56'd0, snap_be_a}, 64'h30);
        chk("t2_be32", {60'd0, snap_be_b}, 64'h3);
        chk("t2_wdata", snap_wd_a, 64'hAABB_CCDD_AABB_CCDD);
        chk("t2_addr", {32'd0, snap_addr_a}, 64'h108);
        chk("t2_strobes", 64'(snap_strobes), 64'd4);

        // Error response on read
        access(32'h200, 32'h0, 4'h0, 1'b0, 1, 2'b10, 64'h1111_2222_3333_4444);
        chk("t3_rdata", {snap_rdata_a, snap_rdata_b}, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t3_irq", 64'(snap_irq), 64'd1);
        chk("t3_err_addr", {32'd0, snap_err_addr}, 64'h200);

        // Error response on write still completes
        access(32'h344, 32'h5566_7788, 4'b1111, 1'b0, 0, 2'b01, 64'h0);
        chk("t4_irq", 64'(snap_irq), 64'd1);
        chk("t4_err_addr", {32'd0, snap_err_addr}, 64'h344);

`ifdef PICORV32_BRIDGE_TIMEOUT_EN
        // Stuck wait-request: aborted after TO strobe cycles
        access(32'h404, 32'h0, 4'h0, 1'b0, 20, 2'b00, 64'h9999_8888_7777_6666);
        chk("t5_strobes", 64'(snap_strobes), 64'd8);
        chk("t5_irq", 64'(snap_irq), 64'd1);
        chk("t5_rdata", {32'd0, snap_rdata_a}, 64'hDEAD_BEEF);
        chk("t5_err_addr", {32'd0, snap_err_addr}, 64'h404);
        // Completion in the last allowed cycle wins over timeout
        access(32'h408, 32'h0, 4'h0, 1'b0, 7, 2'b00, 64'h9999_8888_7777_6666);
        chk("t6_strobes", 64'(snap_strobes), 64'd8);
        chk("t6_irq", 64'(snap_irq), 64'd0);
        chk("t6_rdata", {32'd0, snap_rdata_a}, 64'h7777_6666);
`else
        // Without timeout a long stall simply completes
        access(32'h404, 32'h0, 4'h0, 1'b0, 12, 2'b00, 64'h9999_8888_7777_6666);
        chk("t5_strobes", 64'(snap_strobes), 64'd13);
        chk("t5_irq", 64'(snap_irq), 64'd0);
        chk("t5_rdata", {32'd0, snap_rdata_a}, 64'h9999_8888);
`endif

        // Reset in the middle of a stalled access
        mem_valid = 1'b1; mem_addr = 32'h500; mem_wstrb = 4'h0; mem_instr = 1'b0;
        e_addr = 32'h500; e_wstrb = 4'h0; e_instr = 1'b0;
        bus_waitrequest = 1'b1;
        @(posedge clk); #1;
        e_strobe = 1'b1;
        @(posedge clk); #1;
        chk("t7_pre_read", {63'd0, bus_read_a}, 64'd1);
        #1;
        rst_n = 1'b0; mem_valid = 1'b0;
        e_strobe = 1'b0; e_err_addr = '0;
        #1;
        chk("t7_strobes", {60'd0, bus_read_a, bus_write_a, bus_read_b, bus_write_b}, 64'd0);
        chk("t7_ready", {62'd0, mem_ready_a, mem_ready_b}, 64'd0);
        chk("t7_irq", {62'd0, err_irq_a, err_irq_b}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(32'h0, 32'h0, 4'h0, 1'b0, 0, 2'b00, 64'h0BAD_F00D_600D_CAFE);
        chk("t7_after", {32'd0, snap_rdata_a}, 64'h600D_CAFE);

        // Back-to-back: instruction fetch then data write
        access(32'h80, 32'h0, 4'h0, 1'b1, 0, 2'b00, 64'h0000_0013_0000_0093);
        chk("t8_instr1", {63'd0, snap_instr}, 64'd1);
        chk("t8_fetch", {32'd0, snap_rdata_b}, 64'h93);
        access(32'h84, 32'h0102_0304, 4'b1100, 1'b0, 0, 2'b00, 64'h0);
        chk("t8_instr0", {63'd0, snap_instr}, 64'd0);
        chk("t8_be64", {56'd0, snap_be_a}, 64'hC0);

        @(posedge clk); @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
